// File: rtl/mem_access_ctrl.sv
// Memory-side MAR/MDR stage: sequences wait-stated read/write strobes into the 512x32 RAM.
// Optional write-verify read-back is enabled by defining MEM_WRITE_VERIFY_EN.
module mem_access_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic [DATA_W-1:0] Mdatain,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] MDR_out,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int CW = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
`ifdef MEM_WRITE_VERIFY_EN
        WV   = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_read;
    logic              r_write;
    logic              r_busy;
    logic              r_done;
    logic              r_verr;
    logic              w_last;

    assign w_last      = (r_cnt == '0);
    assign ram_address = r_mar;
    assign ram_wdata   = r_mdr;
    assign MDR_out     = r_mdr;
    assign ram_read    = r_read;
    assign ram_write   = r_write;
    assign busy        = r_busy;
    assign done        = r_done;
`ifdef MEM_WRITE_VERIFY_EN
    assign verify_err  = r_verr;
`else
    assign verify_err  = 1'b0;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_verr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // Loads land on this edge, so a same-cycle request sees them when the strobe rises.
                    if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) r_mdr <= BusMuxOut;
                    if (Read && !Write) begin
                        r_state <= RD;
                        r_cnt   <= CNT_LOAD;
                        r_read  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_verr  <= 1'b0;
                    end else if (Write && !Read) begin
                        r_state <= WR;
                        r_cnt   <= CNT_LOAD;
                        r_write <= 1'b1;
                        r_busy  <= 1'b1;
                        r_verr  <= 1'b0;
                    end
                end
                RD: begin
                    if (w_last) begin
                        r_mdr   <= Mdatain;
                        r_read  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR: begin
                    if (w_last) begin
                        r_write <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
                        r_read  <= 1'b1;
                        r_cnt   <= CNT_LOAD;
                        r_state <= WV;
`else
                        r_done  <= 1'b1;
                        r_state <= DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef MEM_WRITE_VERIFY_EN
                WV: begin
                    if (w_last) begin
                        if (Mdatain != r_mdr) r_verr <= 1'b1;
                        r_read  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: IDLE load vectors from a table, plus hand-written operation sequences.
module tb_mem_access_ctrl;

    localparam int WS = 2;
`ifdef MEM_WRITE_VERIFY_EN
    localparam int WR_DONE_CYC = 2 * WS + 3;
`else
    localparam int WR_DONE_CYC = WS + 2;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic [31:0] Mdatain;
    logic [8:0]  ram_address;
    logic        ram_read, ram_write, busy, done, verify_err;
    logic [31:0] ram_wdata, MDR_out;

    logic        d0_MARin = 1'b0, d0_MDRin = 1'b0, d0_Read = 1'b0, d0_Write = 1'b0;
    logic [31:0] d0_bus = '0;
    logic [31:0] d0_Mdatain;
    logic [8:0]  d0_ram_address;
    logic        d0_ram_read, d0_ram_write, d0_busy, d0_done, d0_verify_err;
    logic [31:0] d0_ram_wdata, d0_MDR_out;

    logic [31:0] mem [512];
    logic        force_zero = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.WAIT_STATES(WS)) u_dut (
        .clock(clock), .clear(clear), .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
        .BusMuxOut(BusMuxOut), .Mdatain(Mdatain), .ram_address(ram_address), .ram_read(ram_read),
        .ram_write(ram_write), .ram_wdata(ram_wdata), .MDR_out(MDR_out), .busy(busy), .done(done),
        .verify_err(verify_err)
    );

    mem_access_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clock(clock), .clear(clear), .MARin(d0_MARin), .MDRin(d0_MDRin), .Read(d0_Read),
        .Write(d0_Write), .BusMuxOut(d0_bus), .Mdatain(d0_Mdatain), .ram_address(d0_ram_address),
        .ram_read(d0_ram_read), .ram_write(d0_ram_write), .ram_wdata(d0_ram_wdata),
        .MDR_out(d0_MDR_out), .busy(d0_busy), .done(d0_done), .verify_err(d0_verify_err)
    );

    // RAM models: the main one is written by the DUT; the WAIT_STATES=0 one returns a fixed word at 0x1FF.
    assign Mdatain    = (ram_read && !force_zero) ? mem[ram_address] : '0;
    assign d0_Mdatain = (d0_ram_read && d0_ram_address == 9'h1FF) ? 32'h1234_5678 : '0;

    always @(posedge clock) if (ram_write) mem[ram_address] <= ram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request, then watches strobes until busy falls (bounded).
    task automatic do_op(input logic is_rd, output int rd_cnt, output int wr_cnt, output int done_cyc,
                         output int done_cnt, output int both, output logic [31:0] mdr_at_done,
                         output logic ve_at_done, output logic ve_cyc1);
        rd_cnt = 0; wr_cnt = 0; done_cyc = 0; done_cnt = 0; both = 0;
        mdr_at_done = 'x; ve_at_done = 1'bx; ve_cyc1 = 1'bx;
        Read = is_rd; Write = !is_rd;
        tick();
        Read = 1'b0; Write = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 1) ve_cyc1 = verify_err;
            if (ram_read) rd_cnt++;
            if (ram_write) wr_cnt++;
            if (ram_read && ram_write) both++;
            if (done) begin
                if (done_cyc == 0) begin
                    done_cyc    = cyc;
                    mdr_at_done = MDR_out;
                    ve_at_done  = verify_err;
                end
                done_cnt++;
            end
            if (done_cyc != 0 && !busy) break;
            tick();
        end
    endtask

    typedef struct {
        logic        marin, mdrin, rd, wr;
        logic [31:0] bus;
        logic [8:0]  exp_addr;
        logic [31:0] exp_mdr;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rc, wc, dc, dn, bt, extra;
        logic [31:0] md;
        logic ve_d, ve_1, addr_ok, wr_seen;

        for (int i = 0; i < 512; i++) mem[i] = 32'h0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0075, 9'h075, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 9'h075, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FE03, 9'h003, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0075, 9'h075, 32'h0000_0075, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 9'h075, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 9'h075, 32'hDEAD_BEEF, 1'b0};

        // Reset state
        #12;
        chk("rst_read", {31'b0, ram_read}, 32'h0);
        chk("rst_write", {31'b0, ram_write}, 32'h0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
        chk("rst_verr", {31'b0, verify_err}, 32'h0);
        chk("rst_mar", {23'b0, ram_address}, 32'h0);
        chk("rst_mdr", MDR_out, 32'h0);
        clear = 1'b0;
        tick();

        // IDLE load vectors, including the illegal Read+Write combination
        foreach (vecs[i]) begin
            MARin = vecs[i].marin; MDRin = vecs[i].mdrin;
            Read = vecs[i].rd; Write = vecs[i].wr; BusMuxOut = vecs[i].bus;
            tick();
            chk($sformatf("vec%0d_addr", i), {23'b0, ram_address}, {23'b0, vecs[i].exp_addr});
            chk($sformatf("vec%0d_mdr", i), MDR_out, vecs[i].exp_mdr);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy | ram_read | ram_write}, {31'b0, vecs[i].exp_busy});
        end
        MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; BusMuxOut = '0;
        tick();
        chk("illegal_still_idle", {30'b0, busy, done}, 32'h0);

        // Write 0xDEADBEEF to 0x075
        do_op(1'b0, rc, wc, dc, dn, bt, md, ve_d, ve_1);
        chk("wr_strobe_cycles", wc, WS + 1);
        chk("wr_done_cycle", dc, WR_DONE_CYC);
        chk("wr_done_width", dn, 1);
        chk("wr_no_overlap", bt, 0);
        chk("wr_ram_word", mem[9'h075], 32'hDEAD_BEEF);
        chk("wr_verr_clean", {31'b0, ve_d}, 32'h0);
`ifdef MEM_WRITE_VERIFY_EN
        chk("wv_read_cycles", rc, WS + 1);
`else
        chk("wr_no_read", rc, 0);
`endif

        // Clear MDR, then read the word back
        MDRin = 1'b1; BusMuxOut = 32'h0;
        tick();
        MDRin = 1'b0;
        chk("mdr_cleared", MDR_out, 32'h0);
        do_op(1'b1, rc, wc, dc, dn, bt, md, ve_d, ve_1);
        chk("rd_strobe_cycles", rc, WS + 1);
        chk("rd_done_cycle", dc, WS + 2);
        chk("rd_done_width", dn, 1);
        chk("rd_mdr_at_done", md, 32'hDEAD_BEEF);
        chk("rd_no_write", wc, 0);

        // Requests and MARin while busy are ignored; held Write is dropped in the DONE cycle
        Read = 1'b1;
        tick();
        Read = 1'b0;
        addr_ok = 1'b1; wr_seen = 1'b0; dc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (ram_address !== 9'h075) addr_ok = 1'b0;
            if (ram_write) wr_seen = 1'b1;
            if (done) begin
                dc = cyc;
                MARin = 1'b0; Write = 1'b0;
                break;
            end
            MARin = 1'b1; BusMuxOut = 32'h0000_0003; Write = 1'b1;
            tick();
        end
        chk("busy_ign_done_cycle", dc, WS + 2);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy || ram_read || ram_write || done) extra++;
            if (ram_address !== 9'h075) addr_ok = 1'b0;
        end
        chk("busy_ign_mar", {31'b0, addr_ok}, 32'h1);
        chk("busy_ign_no_write", {31'b0, wr_seen}, 32'h0);
        chk("busy_ign_no_second_op", extra, 0);

        // Asynchronous clear mid-RD
        Read = 1'b1;
        tick();
        Read = 1'b0;
        chk("pre_clear_read", {31'b0, ram_read}, 32'h1);
        clear = 1'b1;
        #1;
        chk("clr_read_drop", {31'b0, ram_read}, 32'h0);
        chk("clr_mar", {23'b0, ram_address}, 32'h0);
        chk("clr_mdr", MDR_out, 32'h0);
        chk("clr_busy", {31'b0, busy}, 32'h0);
        #2 clear = 1'b0;
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || ram_read) dn++;
        end
        chk("clr_no_done", dn, 0);

        // WAIT_STATES=0 instance, wrap-edge address loaded in the same cycle as the request
        d0_MARin = 1'b1; d0_bus = 32'h0000_01FF; d0_Read = 1'b1;
        tick();
        d0_MARin = 1'b0; d0_Read = 1'b0;
        chk("ws0_addr", {23'b0, d0_ram_address}, 32'h1FF);
        chk("ws0_read_c1", {30'b0, d0_ram_read, d0_done}, 32'h2);
        tick();
        chk("ws0_done_c2", {30'b0, d0_ram_read, d0_done}, 32'h1);
        chk("ws0_mdr", d0_MDR_out, 32'h1234_5678);
        tick();
        chk("ws0_idle_c3", {29'b0, d0_busy, d0_ram_read, d0_done}, 32'h0);

        // Write with RAM read-back forced to zero, then a read that clears the flag
        MARin = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h0000_0075;
        tick();
        MARin = 1'b0; BusMuxOut = 32'hA5A5_A5A5;
        tick();
        MDRin = 1'b0;
        force_zero = 1'b1;
        do_op(1'b0, rc, wc, dc, dn, bt, md, ve_d, ve_1);
        force_zero = 1'b0;
        chk("vf_wr_done_cycle", dc, WR_DONE_CYC);
        chk("vf_mdr_kept", MDR_out, 32'hA5A5_A5A5);
`ifdef MEM_WRITE_VERIFY_EN
        chk("vf_err_at_done", {31'b0, ve_d}, 32'h1);
        chk("vf_err_sticky", {31'b0, verify_err}, 32'h1);
`else
        chk("vf_err_tied", {31'b0, ve_d}, 32'h0);
`endif
        do_op(1'b1, rc, wc, dc, dn, bt, md, ve_d, ve_1);
        chk("vf_err_cleared", {31'b0, ve_1}, 32'h0);
        chk("vf_rd_mdr", md, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side interface stage directly upstream of the 512x32 RAM.
- Holds MAR (9-bit address) and MDR (32-bit data).
- Sequences level-sensitive read/write strobes into the RAM with a programmable number of wait states, captures RAM read data (Mdatain) into MDR, and signals completion to the control unit.
- Guarantees the RAM's address and write data are stable for the whole time its strobes are high.

Parameters:
- WAIT_STATES, 2, extra cycles each RAM strobe is held beyond the minimum one (range 0..15).
- ADDR_W, 9, RAM address width (MAR width).
- DATA_W, 32, datapath width.

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  asynchronous active-high reset
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0] (IDLE only)
- MDRin  in  1  load MDR from BusMuxOut (IDLE only)
- Read  in  1  request memory read at address MAR (sampled on clock edge)
- Write  in  1  request memory write of MDR to address MAR (sampled on clock edge)
- BusMuxOut  in  32  internal CPU bus
- Mdatain  in  32  RAM read data (Z when RAM is not reading)
- ram_address  out  9  to RAM address; always equals MAR
- ram_read  out  1  to RAM read strobe
- ram_write  out  1  to RAM write strobe
- ram_wdata  out  32  to RAM BusMuxOut input; always equals MDR
- MDR_out  out  32  MDR contents to the bus mux; always equals MDR
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- verify_err  out  1  write-verify mismatch flag (see Optional Feature)

Behaviour:
- Reset (clear=1, asynchronous):
  - state = IDLE; MAR = 0; MDR = 0; wait counter = 0.
  - ram_read = 0, ram_write = 0, done = 0, verify_err = 0, all immediately.
  - Reset mid-operation aborts the operation with no done pulse. A write aborted this way may have partially occurred and is not retried.
- Outputs: ram_read, ram_write, done and busy are registered. Counter width is max(1, clog2(WAIT_STATES+1)).
- FSM states: IDLE, RD, WR, DONE (plus WV with the Optional Feature).
- IDLE:
  - MARin and MDRin load on the clock edge.
  - Read=1 and Write=0: go to RD and load counter = WAIT_STATES.
  - Write=1 and Read=0: go to WR and load counter = WAIT_STATES.
  - Read=1 and Write=1: illegal. No transition, no strobe, no done.
  - MARin/MDRin in the same cycle as a request: the loaded value is used by that request, because the strobe rises on the next cycle.
- RD:
  - ram_read = 1; counter decrements each cycle.
  - In the cycle the counter is 0: MDR <= Mdatain, then go to DONE.
- WR:
  - ram_write = 1; counter decrements each cycle.
  - When the counter is 0: go to DONE (or to WV if the feature is enabled).
- DONE: done = 1 and strobes = 0 for exactly one cycle, then go to IDLE.
- Latency: strobe high for exactly WAIT_STATES+1 cycles, starting the cycle after the request edge. done is high in cycle WAIT_STATES+2 after the request edge.
- Strobes:
  - ram_read and ram_write are never high together.
  - Both are low for at least one cycle between consecutive operations (the DONE cycle).
- While busy:
  - MARin, MDRin, Read and Write are ignored; MAR and MDR stay frozen.
  - The exception is the MDR capture in RD.
- Requests are level-sampled. A Read/Write still held during the DONE cycle starts no new operation. A request held into the following IDLE cycle starts a new one.

Optional Feature:
- Macro: MEM_WRITE_VERIFY_EN.
- Defined:
  - After WR the FSM enters WV and drives ram_read = 1 for WAIT_STATES+1 cycles (counter reloaded).
  - In WV's last cycle it compares Mdatain with MDR. On mismatch, verify_err is set.
  - Then go to DONE. Write latency grows by WAIT_STATES+1 cycles.
  - verify_err is sticky; it is cleared by clear or when the next Read/Write is accepted.
  - MDR is not overwritten in WV.
- Undefined: no WV state; verify_err is tied to 0.

Test Plan:
- clear pulse mid-RD (WAIT_STATES=2) -> ram_read drops in the same cycle; MAR=0, MDR=0, busy=0; no done.
- MARin with bus=0x0000_0075, MDRin with bus=0xDEAD_BEEF, then Write -> ram_address=0x075, ram_wdata=0xDEADBEEF, ram_write high for 3 cycles, done in cycle 4; RAM word 0x75=0xDEADBEEF.
- MAR=0x075, Read (RAM returns 0xDEADBEEF) -> ram_read high 3 cycles; MDR_out=0xDEADBEEF when done; done lasts exactly 1 cycle.
- WAIT_STATES=0: Read at MAR=0x1FF, word=0x1234_5678 -> ram_read high 1 cycle, done at cycle 2, MDR=0x12345678 (wrap-edge address).
- During RD, assert MARin with bus=0x0000_0003 and Write=1 -> MAR stays 0x075, no write strobe, and no second operation after done once the requests are dropped. Separately, Read=Write=1 in IDLE -> busy stays 0.
- With MEM_WRITE_VERIFY_EN and RAM forced to return 0x0 -> write 0xA5A5A5A5; verify_err=1 at done, and it clears on the next accepted Read.
